port_uart_tx: RTL and testbench
===============================

// Module: port_uart_tx
// PURPOSE
//  Port-bus UART transmitter peripheral. It is the responder side of the PicoBlaze
//  port_id/out_port/write_strobe/read_strobe bus.
//  - Processor writes queue bytes into an internal FIFO.
//  - Bytes are serialized as 8N1, LSB first, on tx.
//  - Status is returned through a read-data word that the top-level in_port mux selects.
// PARAMETERS
//  BIT_CLKS    868    clk cycles per bit period (100 MHz / 115200); legal 2..65535
//  FIFO_AW     4      FIFO address width; depth = 2**FIFO_AW entries
//  DATA_PORT   8'h10  write: push byte; read: returns 8'h00
//  CTRL_PORT   8'h11  write: bit0 = clear overflow, bit1 = flush FIFO
//  STAT_PORT   8'h12  read: status word
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  port_id       in   8  port address from processor
//  out_port      in   8  write data from processor
//  write_strobe  in   1  one-cycle write qualifier
//  read_strobe   in   1  one-cycle read qualifier
//  rd_data       out  8  combinational read data for the addressed port
//  rd_sel        out  1  combinational; 1 when port_id equals DATA_PORT, CTRL_PORT or STAT_PORT
//  tx            out  1  serial output, idle high
//  tx_busy       out  1  1 while a frame is on the line or the FIFO is non-empty
// BEHAVIOUR
//  Reset (async assert, sync release): tx=1, FSM=IDLE, FIFO empty, overflow=0, counters=0.
//  Decode: full 8-bit compare of port_id against the three ports.
//  Push (write_strobe && port_id==DATA_PORT):
//   - out_port is written at FIFO tail.
//   - The push is accepted iff !full, or a pop occurs in the same cycle.
//   - Otherwise the byte is dropped and overflow<=1 (sticky).
//  CTRL write:
//   - bit0=1 clears overflow; a simultaneous overflow event wins (overflow stays 1).
//   - bit1=1 empties the FIFO (head=tail) and discards any push in the same cycle.
//   - A frame already in shift register is not aborted.
//  STAT read word, combinational from registered state:
//   {4'b0, overflow, fsm_idle, full, empty}.
//   Reads have no side effects.
//  FIFO: circular, pointers wrap modulo depth, extra pointer bit distinguishes full/empty.
//   Count 0..2**FIFO_AW.
//  FSM states:
//   - IDLE: tx=1. If FIFO non-empty, pop the head into shift reg, clear baud_cnt and go to START.
//     The pop is in the same cycle.
//   - START: tx=0 for BIT_CLKS cycles, then DATA with bit_idx=0.
//   - DATA: tx=shift[0] for BIT_CLKS cycles, then shift right and bit_idx++.
//     After bit_idx==7, go to STOP.
//   - STOP: tx=1 for BIT_CLKS cycles, then IDLE.
//     IDLE can pop again on the next cycle, giving back-to-back frames with exactly one idle
//     cycle between stop bit and next start bit.
//  Latency:
//   - Push at edge N into an empty FIFO with FSM idle: FIFO non-empty after N.
//   - FSM pops at edge N+1; tx falls after edge N+1.
//   - A frame occupies 10*BIT_CLKS cycles.
//  tx is driven from a register; no glitches.
//  tx_busy = !fsm_idle || !empty.
//  Reset mid-frame: tx returns to 1 immediately (async); all queued data is lost.
// TESTING (sim with BIT_CLKS=4, FIFO_AW=2)
//  1. Reset: hold reset_n=0 for 5 cycles.
//     -> tx=1, tx_busy=0; STAT read = 8'h05 (idle=1, empty=1).
//  2. Write 8'hA5 to DATA_PORT -> tx sequence, each level held 4 clk:
//     0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop).
//     Start bit begins 2 cycles after the strobe; STAT=8'h05 after 40 more cycles.
//  3. Push 8'h01, 02, 03, 04, 05 in 5 consecutive cycles while idle.
//     -> The first is popped immediately, so all 5 are accepted (4 in FIFO + 1 in shifter).
//     -> overflow=0; frames come out in order with 1 idle cycle between frames.
//     A 6th push while full -> dropped, STAT bit3=1.
//  4. With overflow=1, write CTRL bit0=1 -> STAT bit3=0.
//     CTRL clear in the same cycle as a full-FIFO push -> bit3 stays 1.
//  5. Queue 3 bytes, write CTRL bit1=1 during the first frame's DATA state.
//     -> The current frame completes; no further frames; STAT=8'h05 after stop bit.
//  6. Drive reset_n=0 mid-DATA of 8'h00 (tx=0) -> tx=1 in the same cycle; after release, no
//     frame is sent.
//     Also check: rd_sel=1 only for ports 8'h10..8'h12; rd_data=8'h00 otherwise.

Source files
------------

// File: rtl/port_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : port_uart_tx_if
//  Description : PicoBlaze-style port bus (port_id/out_port/strobes/read data)
//  Revision    : 1.0  initial release
// ============================================================================
interface port_uart_tx_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] rd_data;
    logic       rd_sel;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        output read_strobe,
        input  rd_data,
        input  rd_sel
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        input  read_strobe,
        output rd_data,
        output rd_sel
    );
endinterface
`default_nettype wire

// File: rtl/port_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : port_uart_tx
//  Description : Port-bus UART transmitter, 8N1 LSB first, with byte FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module port_uart_tx #(
    parameter int         BIT_CLKS  = 868,
    parameter int         FIFO_AW   = 4,
    parameter logic [7:0] DATA_PORT = 8'h10,
    parameter logic [7:0] CTRL_PORT = 8'h11,
    parameter logic [7:0] STAT_PORT = 8'h12
) (
    input  wire             clk,
    input  wire             reset_n,
    port_uart_tx_if.slave   bus,
    output logic            tx,
    output logic            tx_busy
);

    localparam int               c_depth    = 2 ** FIFO_AW;
    localparam logic [15:0]      c_bit_last = 16'(BIT_CLKS - 1);
    localparam logic [FIFO_AW:0] c_ptr_one  = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Reset asserts asynchronously but is released on a clock edge
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [7:0]       r_mem [c_depth];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             r_overflow;
    state_t           r_state;
    logic [15:0]      r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic w_sel_data, w_sel_ctrl, w_sel_stat;
    logic w_empty, w_full, w_idle, w_pop;
    logic w_push_req, w_push, w_ovf_event;
    logic w_ctrl_wr, w_flush, w_clear, w_bit_end;
    logic w_unused_rd;

    assign w_sel_data  = (bus.port_id == DATA_PORT);
    assign w_sel_ctrl  = (bus.port_id == CTRL_PORT);
    assign w_sel_stat  = (bus.port_id == STAT_PORT);

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                         (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_idle      = (r_state == S_IDLE);
    assign w_pop       = w_idle && !w_empty;

    assign w_ctrl_wr   = bus.write_strobe && w_sel_ctrl;
    assign w_flush     = w_ctrl_wr && bus.out_port[1];
    assign w_clear     = w_ctrl_wr && bus.out_port[0];

    // A full FIFO still takes a byte when the FSM pops the head in the same cycle
    assign w_push_req  = bus.write_strobe && w_sel_data;
    assign w_push      = w_push_req && (!w_full || w_pop) && !w_flush;
    assign w_ovf_event = w_push_req && w_full && !w_pop;

    assign w_bit_end   = (r_baud_cnt == c_bit_last);

    // Reads have no side effects, so the read qualifier is intentionally ignored
    assign w_unused_rd = bus.read_strobe;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= bus.out_port;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end else if (w_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.rd_data = 8'h00;
        if (w_sel_stat) begin
            bus.rd_data = {4'b0000, r_overflow, w_idle, w_full, w_empty};
        end
    end

    assign bus.rd_sel = w_sel_data || w_sel_ctrl || w_sel_stat;
    assign tx         = r_tx;
    assign tx_busy    = !w_idle || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_port_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_port_uart_tx
//  Description : Self-checking bench for port_uart_tx against a frame model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_port_uart_tx;

    localparam int BIT_CLKS = 4;
    localparam int FIFO_AW  = 2;
    localparam int FRAME    = 10 * BIT_CLKS;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic tx;
    logic tx_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    port_uart_tx_if bus ();

    port_uart_tx #(
        .BIT_CLKS  (BIT_CLKS),
        .FIFO_AW   (FIFO_AW),
        .DATA_PORT (8'h10),
        .CTRL_PORT (8'h11),
        .STAT_PORT (8'h12)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    // Line level of bit period k of an 8N1 frame: start, LSB-first data, stop
    function automatic logic frame_level(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        bus.port_id      = 8'h10;
        bus.out_port     = b;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h00;
    endtask

    task automatic ctrl_write(input logic [7:0] v);
        bus.port_id      = 8'h11;
        bus.out_port     = v;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h00;
    endtask

    task automatic read_stat(output logic [7:0] v);
        bus.port_id     = 8'h12;
        bus.read_strobe = 1'b1;
        #1;
        v               = bus.rd_data;
        bus.read_strobe = 1'b0;
        bus.port_id     = 8'h00;
    endtask

    // Consumes n bytes from exp_q and checks every cycle of each frame on tx
    task automatic check_frames(input int n);
        int         waited;
        logic [7:0] b;
        waited = 0;
        while (tx !== 1'b0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: tx=%b required 0 within 60 cycles", tx);
            return;
        end
        for (int f = 0; f < n; f++) begin
            if (exp_q.size() == 0) break;
            b = exp_q.pop_front();
            for (int i = 0; i < FRAME; i++) begin
                checks++;
                if (tx !== frame_level(b, i / BIT_CLKS)) begin
                    errors++;
                    $display("FAIL frame_bit: byte=%02h cycle=%0d tx=%b required %b",
                             b, i, tx, frame_level(b, i / BIT_CLKS));
                end
                @(negedge clk);
            end
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL idle_gap: byte=%02h tx=%b required 1", b, tx);
            end
            if (f < n - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: tx=%b busy=%b required tx=1 busy=0", tx, tx_busy);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        read_stat(v);
        checks++;
        if (v !== 8'h05) begin
            errors++;
            $display("FAIL reset_stat: got %02h required 05", v);
        end
    endtask

    task automatic test_single();
        logic [7:0] v;
        push_byte(8'hA5);
        read_stat(v);
        checks++;
        if (v !== 8'h04 || tx !== 1'b1 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_queued: stat=%02h tx=%b busy=%b required 04/1/1", v, tx, tx_busy);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: tx=%b required 0 one cycle after push", tx);
        end
        exp_q.push_back(8'hA5);
        check_frames(1);
        read_stat(v);
        checks++;
        if (v !== 8'h05 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: stat=%02h busy=%b required 05/0", v, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [5];
        logic [7:0] v;
        for (int k = 0; k < 5; k++) begin
            data[k] = 8'($urandom);
            exp_q.push_back(data[k]);
        end
        fork
            begin
                for (int k = 0; k < 5; k++) push_byte(data[k]);
                push_byte(8'($urandom));
                read_stat(v);
                checks++;
                if (v !== 8'h0A) begin
                    errors++;
                    $display("FAIL overflow_set: stat=%02h required 0A", v);
                end
            end
            begin
                check_frames(5);
            end
        join
        read_stat(v);
        checks++;
        if (v !== 8'h0D) begin
            errors++;
            $display("FAIL burst_done: stat=%02h required 0D", v);
        end
    endtask

    task automatic test_overflow_clear();
        logic [7:0] v;
        ctrl_write(8'h00);
        read_stat(v);
        checks++;
        if (v !== 8'h0D) begin
            errors++;
            $display("FAIL ctrl_noclear: stat=%02h required 0D", v);
        end
        ctrl_write(8'h01);
        read_stat(v);
        checks++;
        if (v !== 8'h05) begin
            errors++;
            $display("FAIL ctrl_clear: stat=%02h required 05", v);
        end
    endtask

    task automatic test_flush();
        logic [7:0] data [3];
        logic [7:0] v;
        int         bad;
        for (int k = 0; k < 3; k++) data[k] = 8'($urandom);
        exp_q.push_back(data[0]);
        fork
            begin
                for (int k = 0; k < 3; k++) push_byte(data[k]);
                repeat (5) @(negedge clk);
                ctrl_write(8'h02);
                read_stat(v);
                checks++;
                if (v !== 8'h01) begin
                    errors++;
                    $display("FAIL flush_stat: stat=%02h required 01", v);
                end
            end
            begin
                check_frames(1);
            end
        join
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_quiet: %0d low cycles after flush, required 0", bad);
        end
        read_stat(v);
        checks++;
        if (v !== 8'h05) begin
            errors++;
            $display("FAIL flush_done: stat=%02h required 05", v);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        int         bad;
        push_byte(8'h00);
        push_byte(8'($urandom));
        repeat (8) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midframe_pre: tx=%b required 0 in data bits", tx);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_async: tx=%b busy=%b required 1/0", tx, tx_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midframe_lost: %0d low cycles after reset, required 0", bad);
        end
        read_stat(v);
        checks++;
        if (v !== 8'h05) begin
            errors++;
            $display("FAIL midframe_stat: stat=%02h required 05", v);
        end
    endtask

    task automatic test_decode();
        logic [7:0] ports [17];
        logic [7:0] p;
        logic       exp_sel;
        logic [7:0] exp_data;
        ports[0] = 8'h00; ports[1] = 8'h0F; ports[2] = 8'h10; ports[3] = 8'h11;
        ports[4] = 8'h12; ports[5] = 8'h13; ports[6] = 8'hFF;
        for (int k = 7; k < 17; k++) ports[k] = 8'($urandom);
        for (int k = 0; k < 17; k++) begin
            p               = ports[k];
            exp_sel         = (p >= 8'h10) && (p <= 8'h12);
            exp_data        = (p == 8'h12) ? 8'h05 : 8'h00;
            bus.port_id     = p;
            bus.read_strobe = 1'b1;
            #1;
            checks++;
            if (bus.rd_sel !== exp_sel) begin
                errors++;
                $display("FAIL decode_sel: port=%02h rd_sel=%b required %b", p, bus.rd_sel, exp_sel);
            end
            checks++;
            if (bus.rd_data !== exp_data) begin
                errors++;
                $display("FAIL decode_data: port=%02h rd_data=%02h required %02h", p, bus.rd_data, exp_data);
            end
            bus.read_strobe = 1'b0;
            @(negedge clk);
        end
        bus.port_id = 8'h00;
    endtask

    initial begin
        bus.port_id      = 8'h00;
        bus.out_port     = 8'h00;
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow_clear();
        test_flush();
        test_reset_midframe();
        test_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish before 500000");
        $fatal(1);
    end

endmodule
`default_nettype wire
